// File: rtl/shift_collect.sv
// shift_collect: serial words -> LENGTH-entry circular buffer, presented as a vector or drained serially.
// Optional macro SHIFT_COLLECT_THRESHOLD_EN adds a registered fifo_threshold output (cnt >= LENGTH/2).
module shift_collect #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  parameter int PTR_LENGTH = 3
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [1:0]                           ctrl_code,
  input  logic                                 in_valid,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 out_ready,
  output logic [0:LENGTH-1][DATA_WIDTH-1:0]    data_out,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                data_read,
  output logic                                 read_valid,
  output logic                                 fifo_full,
  output logic                                 fifo_empty,
  output logic                                 fifo_overflow,
  output logic                                 fifo_underflow,
  output logic [PTR_LENGTH-1:0]                cnt
`ifdef SHIFT_COLLECT_THRESHOLD_EN
  ,
  output logic                                 fifo_threshold
`endif
);
  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT, DRAIN} state_t;
  localparam logic [PTR_LENGTH-1:0] FULL = PTR_LENGTH'(LENGTH);
  localparam logic [PTR_LENGTH-1:0] LAST = PTR_LENGTH'(LENGTH - 1);
  localparam logic [PTR_LENGTH-1:0] HALF = PTR_LENGTH'(LENGTH / 2);
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [LENGTH];
  logic [DATA_WIDTH-1:0] mem_nxt [LENGTH];
  logic [0:LENGTH-1][DATA_WIDTH-1:0] vec;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [PTR_LENGTH-1:0] wptr, rptr, wptr_base, rptr_base, cnt_base;
  logic [PTR_LENGTH-1:0] wptr_nxt, rptr_nxt, cnt_nxt;
  logic flush, collect_mode, drain_mode, handoff, full_now;
  logic wr, rd, ovf, udf, fill, out_valid_nxt;
  function automatic logic [PTR_LENGTH-1:0] inc(input logic [PTR_LENGTH-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    flush        = ctrl_code == 2'b10;
    collect_mode = ctrl_code == 2'b01 && (state == IDLE || state == COLLECT);
    drain_mode   = ctrl_code == 2'b11 && state != PRESENT;
    handoff      = state == PRESENT && out_ready && !flush;
    full_now     = cnt == FULL;
    wr           = in_valid && ((collect_mode && !full_now) || handoff);
    ovf          = in_valid && full_now && !handoff && (collect_mode || (state == PRESENT && !flush));
    rd           = drain_mode && cnt != '0;
    udf          = drain_mode && cnt == '0;
    // A handoff empties the buffer first, so a same-cycle write lands in entry 0
    wptr_base    = handoff ? '0 : wptr;
    rptr_base    = handoff ? '0 : rptr;
    cnt_base     = handoff ? '0 : cnt;
    cnt_nxt      = flush ? '0 : wr ? cnt_base + 1'b1 : rd ? cnt - 1'b1 : cnt_base;
    wptr_nxt     = flush ? '0 : wr ? inc(wptr_base) : wptr_base;
    rptr_nxt     = flush ? '0 : rd ? inc(rptr) : rptr_base;
    fill         = wr && cnt_nxt == FULL;
    rd_word      = '0;
    for (int k = 0; k < LENGTH; k++) begin
      mem_nxt[k] = (wr && wptr_base == PTR_LENGTH'(k)) ? in_data : mem[k];
      rd_word    = (rptr == PTR_LENGTH'(k)) ? mem[k] : rd_word;
    end
    vec = '0;
    for (int i = 0; i < LENGTH; i++)
      for (int k = 0; k < LENGTH; k++)
        vec[i] = (rptr_base == PTR_LENGTH'((k - i + LENGTH) % LENGTH)) ? mem_nxt[k] : vec[i];
    out_valid_nxt = !flush && (fill || (out_valid && !handoff));
    state_nxt = flush ? IDLE :
                fill ? PRESENT :
                state == PRESENT ? (handoff ? (ctrl_code == 2'b01 ? COLLECT : IDLE) : PRESENT) :
                drain_mode ? DRAIN :
                state == DRAIN ? IDLE :
                collect_mode ? COLLECT : state;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      mem            <= '{default: '0};
      wptr           <= '0;
      rptr           <= '0;
      cnt            <= '0;
      data_out       <= '0;
      out_valid      <= 1'b0;
      data_read      <= '0;
      read_valid     <= 1'b0;
      fifo_full      <= 1'b0;
      fifo_empty     <= 1'b1;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
`ifdef SHIFT_COLLECT_THRESHOLD_EN
      fifo_threshold <= 1'b0;
`endif
    end else begin
      state          <= state_nxt;
      mem            <= mem_nxt;
      wptr           <= wptr_nxt;
      rptr           <= rptr_nxt;
      cnt            <= cnt_nxt;
      data_out       <= fill ? vec : data_out;
      out_valid      <= out_valid_nxt;
      data_read      <= rd ? rd_word : data_read;
      read_valid     <= rd;
      fifo_full      <= cnt_nxt == FULL;
      fifo_empty     <= cnt_nxt == '0;
      fifo_overflow  <= ovf;
      fifo_underflow <= udf;
`ifdef SHIFT_COLLECT_THRESHOLD_EN
      fifo_threshold <= cnt_nxt >= HALF;
`endif
    end
  end
endmodule

// File: doc/shift_collect.md
SHIFT_COLLECT -- requirements
Module: shift_collect

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, word width; LENGTH, 4, words per vector; PTR_LENGTH, 3, pointer/counter width (2^PTR_LENGTH > LENGTH).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 ctrl_code  input  2  00 hold, 01 collect, 10 flush, 11 drain.
REQ-005 in_valid  input  1  in_data qualifier during collect.
REQ-006 in_data  input  DATA_WIDTH  serial word from array edge.
REQ-007 out_ready  input  1  consumer accepts data_out vector.
REQ-008 data_out  output  [0:LENGTH-1][DATA_WIDTH-1:0]  assembled vector; index 0 = oldest word.
REQ-009 out_valid  output  1  data_out holds LENGTH collected words.
REQ-010 data_read  output  DATA_WIDTH  serial word popped in drain mode.
REQ-011 read_valid  output  1  data_read updated this cycle.
REQ-012 fifo_full, fifo_empty  output  1 each  cnt==LENGTH / cnt==0.
REQ-013 fifo_overflow, fifo_underflow  output  1 each  one-cycle error pulses.
REQ-014 cnt  output  PTR_LENGTH  words stored.

Function
REQ-015 Storage SHALL be a LENGTH-entry circular buffer with wptr/rptr wrapping from LENGTH-1 to 0.
REQ-016 States SHALL be IDLE, COLLECT, PRESENT, DRAIN; ctrl 01 in IDLE -> COLLECT, ctrl 11 in IDLE/COLLECT -> DRAIN, ctrl 00 -> hold state and contents.
REQ-017 COLLECT: in_valid=1 and not full SHALL write in_data to mem[wptr], advance wptr, cnt+1.
REQ-018 Write making cnt==LENGTH SHALL move to PRESENT; out_valid SHALL assert the next cycle (1-cycle latency) with data_out[i]=mem[(rptr+i) mod LENGTH].
REQ-019 PRESENT: out_valid and data_out SHALL hold stable until out_ready=1; on that edge cnt, wptr, rptr SHALL clear, out_valid deassert next cycle, state -> COLLECT if ctrl 01 else IDLE.
REQ-020 in_valid=1 while full (including PRESENT) SHALL drop the word and pulse fifo_overflow for one cycle; storage unchanged.
REQ-021 in_valid and out_ready in the same PRESENT cycle SHALL accept the handoff and write in_data into entry 0 of the emptied buffer (cnt=1), no overflow.
REQ-022 DRAIN: each cycle with cnt>0 SHALL register data_read=mem[rptr], pulse read_valid, advance rptr, cnt-1; 1-cycle latency.
REQ-023 DRAIN with cnt==0 SHALL pulse fifo_underflow, leave data_read unchanged, read_valid=0; state -> IDLE when ctrl leaves 11.
REQ-024 ctrl 10 (flush) SHALL in one cycle clear cnt, pointers, out_valid, read_valid, error flags, state -> IDLE; mem contents need not clear.
REQ-025 fifo_full/fifo_empty SHALL be registered, consistent with cnt in the same cycle.
REQ-026 ctrl change mid-collect SHALL not lose stored words except via flush or reset.

Reset
REQ-027 reset_n=0 at a clock edge SHALL set state IDLE, cnt/wptr/rptr 0, mem and data_out 0, data_read 0, out_valid/read_valid/fifo_full/overflow/underflow 0, fifo_empty 1.
REQ-028 Reset SHALL override any ctrl_code, including mid-PRESENT and mid-DRAIN; first action permitted the cycle after reset_n=1.

Configuration
REQ-029 Macro SHIFT_COLLECT_THRESHOLD_EN defined: extra output fifo_threshold (1 bit, registered) SHALL assert when cnt >= LENGTH/2, reset 0.
REQ-030 Macro undefined: fifo_threshold port and logic SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset 4 cycles, ctrl 01, in_valid with 1,2,3,4 -> out_valid 1 cycle after 4th write, data_out={1,2,3,4}, fifo_full=1.
REQ-032 Hold out_ready=0 for 5 cycles with in_valid=1, in_data=9 -> data_out stable {1,2,3,4}, fifo_overflow pulses each cycle, cnt=4.
REQ-033 out_ready=1 and in_valid=1 in_data=5 same cycle -> out_valid drops next cycle, cnt=1, mem[0]=5.
REQ-034 Load 7,8 then ctrl 11 for 3 cycles -> data_read 7 then 8 with read_valid, third cycle fifo_underflow=1, fifo_empty=1.
REQ-035 Load 1,2,3, ctrl 10 one cycle -> cnt=0, fifo_empty=1; reset_n=0 asserted during PRESENT -> all outputs at reset values next edge.
REQ-036 With SHIFT_COLLECT_THRESHOLD_EN, LENGTH=4: fifo_threshold 0 at cnt=1, 1 at cnt=2, 0 after handoff.
